multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the sequential (multi-cycle) RV64 core. It fetches an instruction over a ready-handshake instruction port and latches it into the IR. It then steps the shared datapath (register file, immediate generator, ALU, data memory) through DECODE/EXEC/MEM/WB, issuing per-cycle enables and mux selects. It supports the implemented subset: R-type ALU, addi, ld, sd, beq.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset; async assert, sync release
- imem_ready  in  1  instruction word valid this cycle (handshake with imem_req)
- instr  in  32  instruction word, sampled when imem_req && imem_ready
- dmem_ready  in  1  data access complete (handshake with dmem_req)
- alu_zero  in  1  ALU result == 0, from datapath
- imem_req  out  1  fetch request
- ir_we  out  1  load instruction register
- pc_we  out  1  PC write strobe
- pc_src  out  1  0 = PC+4, 1 = PC_old + imm (branch target)
- rf_we  out  1  register file write enable
- alu_src_imm  out  1  ALU operand B: 0 = rs2, 1 = imm_data
- alu_op  out  2  00 add, 01 sub, 10 decode from funct3/funct7
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = load data
- retire  out  1  one-cycle pulse in final cycle of each instruction
- illegal  out  1  sticky: unsupported opcode seen (macro-dependent)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE is entered on reset. It moves to FETCH unconditionally on the next clk.
- FETCH: imem_req=1 and hold until imem_ready.
  - When imem_ready=1, assert ir_we=1 and pc_we=1 (pc_src=0), latch opcode = instr[6:0], then go to DECODE.
- DECODE: classify the latched opcode.
  - 0110011 R, 0010011 addi, 0000011 ld, 0100011 sd, 1100011 beq.
  - Known opcode: go to EXEC.
  - Unknown opcode: see Configuration.
- EXEC: drive alu_src_imm and alu_op from the opcode class.
  - R: alu_src_imm=0, alu_op=10.
  - addi/ld/sd: alu_src_imm=1, alu_op=00.
  - beq: alu_src_imm=0, alu_op=01. If alu_zero=1, also pc_we=1 and pc_src=1.
  - Next state: beq → FETCH with retire=1; ld/sd → MEM; R/addi → WB.
- MEM: dmem_req=1, dmem_we=1 for sd. Hold until dmem_ready.
  - sd → FETCH with retire=1.
  - ld → WB.
- WB: rf_we=1, mem_to_reg=1 for ld, then go to FETCH with retire=1.
- All outputs are a combinational function of the registered state plus the latched opcode class and the inputs named above. No other inputs feed the outputs.

## Timing
- Reset values: every output is 0, including illegal; state is IDLE.
- Latency with zero-wait memories, counted from the FETCH cycle through the retire cycle:
  - beq 3 cycles.
  - R/addi/sd 4 cycles.
  - ld 5 cycles.
  - Each imem/dmem wait cycle adds 1.
- Handshakes:
  - A request, once asserted, stays high until the ready cycle.
  - ready while the request is low is ignored.
  - The transfer occurs in the cycle where both are high.
- ir_we/pc_we in FETCH occur only in the imem_ready cycle. PC+4 is committed at fetch. The branch target uses the datapath's PC_old.
- Reset mid-instruction: state returns to IDLE immediately. Outputs drop to 0 asynchronously. No partial rf/dmem write after reset assertion.
- beq with alu_zero=0: pc_we stays 0 in EXEC.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - Unknown opcode in DECODE → HALT and illegal=1.
  - HALT is terminal and all other outputs are 0; only rst_n exits it.
- Undefined:
  - Unknown opcode is a NOP. DECODE → FETCH with retire=1, no rf/dmem/pc side effects.
  - illegal is tied 0 and HALT is unreachable.

## Structure
- Shared defines header (riscv_defs): opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), ALU_OP encodings, state encoding. The immediate generator already keys on these opcode values, so both blocks share them.
- One sub-module, ctrl_opclass_dec: combinational opcode → one-hot class {r, imm, ld, sd, br, unk}. The FSM registers its output at ir_we.

## Test plan
- addi x1,x0,5 (0x00500093), imem_ready=1 always → states F,D,E,W.
  - alu_src_imm=1 in E; rf_we=1 in W.
  - retire at cycle 4; pc_we only in cycle 1.
- ld (0x00013083), dmem_ready delayed 2 cycles → dmem_req held 3 cycles, dmem_we=0, mem_to_reg=1 and rf_we=1 in W, retire at cycle 7.
- beq (0x00208463):
  - alu_zero=1 → pc_we=1, pc_src=1 in E, retire cycle 3.
  - Repeat with alu_zero=0 → pc_we=0 in E.
- sd (0x00113023), imem_ready low 3 cycles → imem_req held, ir_we single pulse, dmem_req=dmem_we=1, rf_we never 1.
- Opcode 0x7F:
  - With ILLEGAL_TRAP_EN → HALT, illegal=1 sticky, imem_req stays 0.
  - Without the macro → retire at cycle 2, next fetch follows.
- rst_n pulled low during MEM of sd → all outputs 0 in the same cycle. After release: IDLE, then FETCH with imem_req=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared RISC-V control definitions for the multi-cycle RV64 core: opcode
// constants (also used by the immediate generator), ALU operation
// encodings, FSM state encoding and the one-hot opcode class type.
// Optional feature macro used by this slice: ILLEGAL_TRAP_EN.
package multicycle_ctrl_pkg;

    // Opcodes (instr[6:0]) of the implemented subset
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation selects presented to the datapath
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    // One-hot opcode class
    typedef struct packed {
        logic r;
        logic imm;
        logic ld;
        logic sd;
        logic br;
        logic unk;
    } opclass_t;

endpackage

// File: rtl/ctrl_opclass_dec.sv
// Combinational opcode classifier: maps instr[6:0] onto a one-hot class.
// Anything outside the implemented subset lands in the 'unk' class.
module ctrl_opclass_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    // Exactly one class bit is set for every opcode value
    always_comb begin
        opclass = '0;
        case (opcode)
            OP_R:      opclass.r   = 1'b1;
            OP_IMM:    opclass.imm = 1'b1;
            OP_LOAD:   opclass.ld  = 1'b1;
            OP_STORE:  opclass.sd  = 1'b1;
            OP_BRANCH: opclass.br  = 1'b1;
            default:   opclass.unk = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV64 core. Fetches over a ready
// handshake, latches the opcode class alongside the IR write, then walks
// the shared datapath through DECODE/EXEC/MEM/WB.
// Macro ILLEGAL_TRAP_EN: when defined, an unknown opcode traps into a
// terminal HALT state with a sticky 'illegal' flag; otherwise it retires
// as a NOP straight out of DECODE.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic [31:0] instr,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        rf_we,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        illegal
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    opclass_t   class_q;
    opclass_t   class_d;
    opclass_t   class_dec;
    logic       known_op;

    // Only the opcode field matters here; the rest of the word goes to the datapath
    logic       unused_instr;
    assign unused_instr = ^instr[31:7];

    ctrl_opclass_dec u_dec (
        .opcode  (instr[6:0]),
        .opclass (class_dec)
    );

    assign known_op = class_q.r | class_q.imm | class_q.ld | class_q.sd | class_q.br;

    // Next state and all control outputs from the registered state and class
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        rf_we       = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_OP_ADD;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    // PC+4 is committed together with the IR load
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (known_op) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
`else
                    retire  = 1'b1;
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                if (class_q.r) begin
                    alu_op  = ALU_OP_FUNCT;
                    state_d = ST_WB;
                end else if (class_q.imm) begin
                    alu_src_imm = 1'b1;
                    state_d     = ST_WB;
                end else if (class_q.ld || class_q.sd) begin
                    alu_src_imm = 1'b1;
                    state_d     = ST_MEM;
                end else begin
                    // beq: compare via subtract, redirect PC_old + imm when equal
                    alu_op  = ALU_OP_SUB;
                    pc_we   = alu_zero;
                    pc_src  = alu_zero;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = class_q.sd;
                if (dmem_ready) begin
                    if (class_q.sd) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                mem_to_reg = class_q.ld;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Opcode class is captured in the same cycle the IR is loaded
    always_comb begin
        class_d = class_q;
        if (ir_we) begin
            class_d = class_dec;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == ST_HALT);
`else
    assign illegal = 1'b0;
`endif

    // State registers; reset forces IDLE and so drops every output at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the expected
// output vector for every cycle it drives; a monitor on the falling edge
// pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_ready;
    logic [31:0] instr;
    logic        dmem_ready;
    logic        alu_zero;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        rf_we;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        dmem_req;
    logic        dmem_we;
    logic        mem_to_reg;
    logic        retire;
    logic        illegal;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .dmem_ready  (dmem_ready),
        .alu_zero    (alu_zero),
        .imem_req    (imem_req),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .rf_we       (rf_we),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .mem_to_reg  (mem_to_reg),
        .retire      (retire),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector bit positions
    localparam logic [12:0] B_IMEM_REQ = 13'h1000;
    localparam logic [12:0] B_IR_WE    = 13'h0800;
    localparam logic [12:0] B_PC_WE    = 13'h0400;
    localparam logic [12:0] B_PC_SRC   = 13'h0200;
    localparam logic [12:0] B_RF_WE    = 13'h0100;
    localparam logic [12:0] B_SRC_IMM  = 13'h0080;
    localparam logic [12:0] B_OP_FUNCT = 13'h0040;
    localparam logic [12:0] B_OP_SUB   = 13'h0020;
    localparam logic [12:0] B_DMEM_REQ = 13'h0010;
    localparam logic [12:0] B_DMEM_WE  = 13'h0008;
    localparam logic [12:0] B_MEM2REG  = 13'h0004;
    localparam logic [12:0] B_RETIRE   = 13'h0002;
    localparam logic [12:0] B_ILLEGAL  = 13'h0001;

    // Hand-derived per-state output patterns
    localparam logic [12:0] V_ZERO     = 13'h0000;
    localparam logic [12:0] V_FWAIT    = B_IMEM_REQ;
    localparam logic [12:0] V_FGO      = B_IMEM_REQ | B_IR_WE | B_PC_WE;
    localparam logic [12:0] V_EX_R     = B_OP_FUNCT;
    localparam logic [12:0] V_EX_IMM   = B_SRC_IMM;
    localparam logic [12:0] V_EX_BEQ_T = B_OP_SUB | B_PC_WE | B_PC_SRC | B_RETIRE;
    localparam logic [12:0] V_EX_BEQ_N = B_OP_SUB | B_RETIRE;
    localparam logic [12:0] V_MEM_LD   = B_DMEM_REQ;
    localparam logic [12:0] V_MEM_SD   = B_DMEM_REQ | B_DMEM_WE;
    localparam logic [12:0] V_MEM_SD_R = B_DMEM_REQ | B_DMEM_WE | B_RETIRE;
    localparam logic [12:0] V_WB_ALU   = B_RF_WE | B_RETIRE;
    localparam logic [12:0] V_WB_LD    = B_RF_WE | B_MEM2REG | B_RETIRE;
    localparam logic [12:0] V_NOP_RET  = B_RETIRE;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks;
    int          errors;
    logic [12:0] act_vec;

    assign act_vec = {imem_req, ir_we, pc_we, pc_src, rf_we, alu_src_imm, alu_op,
                      dmem_req, dmem_we, mem_to_reg, retire, illegal};

    // Monitor: one comparison per driven cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            checks = checks + 1;
            if (act_vec !== e.exp) begin
                errors = errors + 1;
                $display("FAIL %s actual=%b expected=%b", e.name, act_vec, e.exp);
            end else begin
                $display("ok   %s outputs=%b", e.name, act_vec);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the expectation
    task automatic cyc(input logic ir, input logic [31:0] iw, input logic dr,
                       input logic az, input logic [12:0] exp, input string name);
        sb_entry_t e;
        @(posedge clk);
        #1;
        imem_ready = ir;
        instr      = iw;
        dmem_ready = dr;
        alu_zero   = az;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LD   = 32'h00013083;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SD   = 32'h00113023;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    initial begin
        sb_entry_t e;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        instr      = 32'h0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then IDLE after release
        cyc(1'b1, I_ADDI, 1'b1, 1'b1, V_ZERO, "reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ready = 1'b0;
        e.exp = V_ZERO; e.name = "idle_after_reset";
        sb_q.push_back(e);

        // addi, zero-wait fetch; ready held high everywhere (ignored off-request)
        cyc(1'b1, I_ADDI, 1'b1, 1'b0, V_FGO,     "addi_fetch");
        cyc(1'b1, I_BAD,  1'b1, 1'b0, V_ZERO,    "addi_decode");
        cyc(1'b1, I_BAD,  1'b1, 1'b0, V_EX_IMM,  "addi_exec");
        cyc(1'b1, I_BAD,  1'b1, 1'b0, V_WB_ALU,  "addi_wb");

        // ld with two dmem wait cycles
        cyc(1'b1, I_LD,   1'b0, 1'b0, V_FGO,     "ld_fetch");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_ZERO,    "ld_decode");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_EX_IMM,  "ld_exec");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_MEM_LD,  "ld_mem_wait1");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_MEM_LD,  "ld_mem_wait2");
        cyc(1'b0, I_BAD,  1'b1, 1'b0, V_MEM_LD,  "ld_mem_done");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_WB_LD,   "ld_wb");

        // beq taken
        cyc(1'b1, I_BEQ,  1'b0, 1'b1, V_FGO,      "beq_t_fetch");
        cyc(1'b0, I_BAD,  1'b0, 1'b1, V_ZERO,     "beq_t_decode");
        cyc(1'b0, I_BAD,  1'b0, 1'b1, V_EX_BEQ_T, "beq_t_exec");

        // beq not taken
        cyc(1'b1, I_BEQ,  1'b0, 1'b0, V_FGO,      "beq_n_fetch");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_ZERO,     "beq_n_decode");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_EX_BEQ_N, "beq_n_exec");

        // sd with three imem wait cycles
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_FWAIT,    "sd_fetch_wait1");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_FWAIT,    "sd_fetch_wait2");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_FWAIT,    "sd_fetch_wait3");
        cyc(1'b1, I_SD,   1'b0, 1'b0, V_FGO,      "sd_fetch");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_ZERO,     "sd_decode");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_EX_IMM,   "sd_exec");
        cyc(1'b0, I_BAD,  1'b1, 1'b0, V_MEM_SD_R, "sd_mem");

        // R-type add
        cyc(1'b1, I_ADD,  1'b0, 1'b0, V_FGO,      "add_fetch");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_ZERO,     "add_decode");
        cyc(1'b0, I_BAD,  1'b0, 1'b1, V_EX_R,     "add_exec");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_WB_ALU,   "add_wb");

        // Unknown opcode
        cyc(1'b1, I_BAD,  1'b1, 1'b1, V_FGO,      "bad_fetch");
`ifdef ILLEGAL_TRAP_EN
        cyc(1'b1, I_ADDI, 1'b1, 1'b1, V_ZERO,     "bad_decode");
        cyc(1'b1, I_ADDI, 1'b1, 1'b1, B_ILLEGAL,  "bad_halt1");
        cyc(1'b1, I_ADDI, 1'b1, 1'b1, B_ILLEGAL,  "bad_halt2");
        cyc(1'b1, I_ADDI, 1'b1, 1'b1, B_ILLEGAL,  "bad_halt3");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        e.exp = V_ZERO; e.name = "halt_reset";
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e.exp = V_ZERO; e.name = "halt_idle";
        sb_q.push_back(e);
`else
        cyc(1'b0, I_BAD,  1'b1, 1'b1, V_NOP_RET,  "bad_nop_retire");
`endif
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_FWAIT,    "after_bad_fetch");

        // sd interrupted by reset while waiting in MEM
        cyc(1'b1, I_SD,   1'b0, 1'b0, V_FGO,      "sdr_fetch");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_ZERO,     "sdr_decode");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_EX_IMM,   "sdr_exec");
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_MEM_SD,   "sdr_mem_wait");
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        dmem_ready = 1'b1;
        imem_ready = 1'b1;
        e.exp = V_ZERO; e.name = "sdr_reset_in_mem";
        sb_q.push_back(e);
        cyc(1'b1, I_SD,   1'b1, 1'b1, V_ZERO,     "sdr_reset_held");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        e.exp = V_ZERO; e.name = "sdr_idle";
        sb_q.push_back(e);
        cyc(1'b0, I_BAD,  1'b0, 1'b0, V_FWAIT,    "sdr_refetch_wait");
        cyc(1'b1, I_ADDI, 1'b0, 1'b0, V_FGO,      "sdr_refetch");

        // Drain the scoreboard within a bounded number of cycles
        repeat (3) @(negedge clk);
        #1;
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
